// File: rtl/gcd_arb_pkg.sv
// Shared types and helpers for the gcd_arbiter slice.
// The state enum, the default operand width and the ID width function.
package gcd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } gcd_arb_state_t;

  localparam int unsigned DefaultDw = 32;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// Bundles the request, response and gcd handshakes of gcd_arbiter.
// slave is the arbiter's view; master is the view of the surrounding logic.
interface gcd_arbiter_if
  import gcd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = DefaultDw
);
  localparam int unsigned IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_a;
  logic [NUM_REQ*DW-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [DW-1:0]         resp_result;
  logic                  resp_error;
  logic                  gcd_start;
  logic [DW-1:0]         gcd_a;
  logic [DW-1:0]         gcd_b;
  logic                  gcd_done;
  logic [DW-1:0]         gcd_result;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, gcd_done, gcd_result,
    output req_ready, resp_valid, resp_id, resp_result, resp_error, gcd_start, gcd_a, gcd_b
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, gcd_done, gcd_result,
    input  req_ready, resp_valid, resp_id, resp_result, resp_error, gcd_start, gcd_a, gcd_b
  );

endinterface

// File: rtl/gcd_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr,
// wrapping modulo NUM_REQ. Produces a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_any
);

  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // rr_ptr and off are both below NUM_REQ, so one subtraction wraps.
      sum = {1'b0, rr_ptr} + (IDW + 1)'(off);
      idx = (sum >= NUM_REQ) ? IDW'(sum - NUM_REQ) : IDW'(sum);
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one gcd unit between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DW             = DefaultDw,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          reset_n,
  gcd_arbiter_if.slave bus
);
  localparam int unsigned IDW = id_width(NUM_REQ);

  gcd_arb_state_t     state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [DW-1:0]      a_q, a_d;
  logic [DW-1:0]      b_q, b_d;
  logic [DW-1:0]      result_q, result_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic [DW-1:0]      sel_a, sel_b;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_rr_arbiter (
    .req_valid(bus.req_valid),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*DW +: DW];
        sel_b = bus.req_b[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef GCD_ARB_TIMEOUT_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          id_d     = grant_idx;
          a_d      = sel_a;
          b_d      = sel_b;
          rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_d  = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef GCD_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      StWait: begin
        // done is only honoured here, so a stale pulse cannot finish a new op.
        if (bus.gcd_done) begin
          result_d = bus.gcd_result;
          state_d  = StResp;
`ifdef GCD_ARB_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (wd_q == CW'(TIMEOUT_CYCLES)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StResp;
        end else begin
          wd_d = wd_q + CW'(1);
`endif
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef GCD_ARB_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  // Gated by reset so that no accept is advertised while reset is held.
  assign bus.req_ready   = ((state_q == StIdle) && reset_n) ? grant : '0;
  assign bus.gcd_start   = (state_q == StIssue);
  assign bus.resp_valid  = (state_q == StResp);
  assign bus.resp_id     = id_q;
  assign bus.resp_result = result_q;
  assign bus.gcd_a       = a_q;
  assign bus.gcd_b       = b_q;
`ifdef GCD_ARB_TIMEOUT_EN
  assign bus.resp_error  = err_q;
`else
  assign bus.resp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter; the bench plays the gcd unit itself.
// The watchdog step is compiled only when GCD_ARB_TIMEOUT_EN is defined.
module tb_gcd_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [31:0] ta [4] = '{32'd12, 32'd35, 32'd17, 32'd100};
  logic [31:0] tb [4] = '{32'd8, 32'd21, 32'd5, 32'd75};
  logic [31:0] tr [4] = '{32'd4, 32'd7, 32'd1, 32'd25};

  gcd_arbiter_if #(.NUM_REQ(NR), .DW(W)) bus ();

  gcd_arbiter #(
    .NUM_REQ       (NR),
    .DW            (W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] euclid(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_valid[i]      = 1'b1;
  endtask

  // Called at a WAIT negedge: answers after lat idle cycles, returns in RESP.
  task automatic finish_gcd(input int unsigned lat);
    repeat (lat) tick();
    bus.gcd_done   = 1'b1;
    bus.gcd_result = euclid(bus.gcd_a, bus.gcd_b);
    tick();
    bus.gcd_done   = 1'b0;
    bus.gcd_result = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_gnt;
    reset_n        = 1'b0;
    bus.req_valid  = '1;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    bus.gcd_done   = 1'b0;
    bus.gcd_result = '0;
    tick();
    #1;
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_gcd_start", bus.gcd_start, 0);
    check("rst_gcd_a", bus.gcd_a, 0);
    check("rst_resp_error", bus.resp_error, 0);
    bus.req_valid = '0;
    reset_n = 1'b1;
    tick();

    // Single request from requester 2.
    set_req(2, 48, 18);
    #1 check("t1_grant", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    check("t1_start", bus.gcd_start, 1);
    check("t1_a", bus.gcd_a, 48);
    check("t1_b", bus.gcd_b, 18);
    check("t1_ready_busy", bus.req_ready, 0);
    tick();
    check("t1_start_once", bus.gcd_start, 0);
    check("t1_a_stable", bus.gcd_a, 48);
    finish_gcd(2);
    check("t1_valid", bus.resp_valid, 1);
    check("t1_id", bus.resp_id, 2);
    check("t1_result", bus.resp_result, 6);
    check("t1_error", bus.resp_error, 0);
    tick();
    check("t1_done", bus.resp_valid, 0);

    // All four valid from reset: grants 0,1,2,3.
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, ta[k], tb[k]);
    for (int k = 0; k < 4; k++) begin
      exp_gnt = 4'b0001 << k;
      #1 check("t2_grant", bus.req_ready, exp_gnt);
      tick();
      bus.req_valid[k] = 1'b0;
      check("t2_start", bus.gcd_start, 1);
      check("t2_a", bus.gcd_a, ta[k]);
      check("t2_b", bus.gcd_b, tb[k]);
      tick();
      finish_gcd(k);
      check("t2_valid", bus.resp_valid, 1);
      check("t2_id", bus.resp_id, k);
      check("t2_result", bus.resp_result, tr[k]);
      tick();
    end
    check("t2_idle", bus.resp_valid, 0);

    // Back-pressure for 10 cycles with another requester waiting.
    bus.resp_ready = 1'b0;
    set_req(1, 54, 24);
    #1 check("t3_grant", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    check("t3_start", bus.gcd_start, 1);
    tick();
    finish_gcd(1);
    set_req(3, 5, 5);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("t3_hold_valid", bus.resp_valid, 1);
      check("t3_hold_id", bus.resp_id, 1);
      check("t3_hold_result", bus.resp_result, 6);
      check("t3_hold_ready", bus.req_ready, 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1 check("t3_last_valid", bus.resp_valid, 1);
    tick();
    check("t3_released", bus.resp_valid, 0);
    check("t3_next_grant", bus.req_ready, 4'b1000);
    bus.req_valid = '0;

    // Stale done high through IDLE and ISSUE.
    bus.gcd_done   = 1'b1;
    bus.gcd_result = 32'hdead;
    set_req(0, 21, 14);
    #1 check("t4_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    check("t4_start", bus.gcd_start, 1);
    check("t4_no_resp_issue", bus.resp_valid, 0);
    tick();
    check("t4_no_resp_wait", bus.resp_valid, 0);
    bus.gcd_done   = 1'b0;
    bus.gcd_result = '0;
    tick();
    check("t4_still_waiting", bus.resp_valid, 0);
    finish_gcd(1);
    check("t4_valid", bus.resp_valid, 1);
    check("t4_id", bus.resp_id, 0);
    check("t4_result", bus.resp_result, 7);
    tick();

    // Reset in the middle of WAIT.
    set_req(2, 9, 6);
    #1 check("t5_grant", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    tick();
    check("t5_in_wait_a", bus.gcd_a, 9);
    set_req(0, 27, 18);
    set_req(3, 40, 10);
    reset_n = 1'b0;
    #1;
    check("t5_rst_a", bus.gcd_a, 0);
    check("t5_rst_b", bus.gcd_b, 0);
    check("t5_rst_start", bus.gcd_start, 0);
    check("t5_rst_valid", bus.resp_valid, 0);
    check("t5_rst_id", bus.resp_id, 0);
    check("t5_rst_result", bus.resp_result, 0);
    check("t5_rst_ready", bus.req_ready, 0);
    tick();
    reset_n = 1'b1;
    #1 check("t5_first_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    check("t5_start", bus.gcd_start, 1);
    check("t5_a", bus.gcd_a, 27);
    tick();
    finish_gcd(0);
    check("t5_id", bus.resp_id, 0);
    check("t5_result", bus.resp_result, 9);
    tick();

`ifdef GCD_ARB_TIMEOUT_EN
    // Watchdog with TIMEOUT_CYCLES=16 and no done.
    set_req(1, 5, 3);
    #1 check("t6_grant", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    check("t6_start", bus.gcd_start, 1);
    tick();
    repeat (16) tick();
    check("t6_not_yet", bus.resp_valid, 0);
    tick();
    check("t6_valid", bus.resp_valid, 1);
    check("t6_error", bus.resp_error, 1);
    check("t6_result", bus.resp_result, 0);
    check("t6_id", bus.resp_id, 1);
    tick();
    check("t6_released", bus.resp_valid, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin scheduler that shares one `gcd` unit between `NUM_REQ` independent requesters. Captures one request at a time and drives the `gcd` `start`/`a_in`/`b_in` handshake. Waits for `done` and returns `result` tagged with the requester ID over a valid/ready response channel. Sits between the requester logic and the single `gcd` instance in the top-level design.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DW`, default 32: operand/result width; must match `gcd`.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit; used only with `GCD_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_a` in NUM_REQ*DW: packed operand A; requester i uses slice [i*DW +: DW].
- `req_b` in NUM_REQ*DW: packed operand B, same packing.
- `req_ready` out NUM_REQ: one-hot accept, combinational.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: response consumer ready.
- `resp_id` out $clog2(NUM_REQ): requester index of the response.
- `resp_result` out DW: GCD result.
- `resp_error` out 1: watchdog abort flag; tied 0 without the macro.
- `gcd_start` out 1: start pulse to `gcd`.
- `gcd_a` out DW: operand to `gcd.a_in`.
- `gcd_b` out DW: operand to `gcd.b_in`.
- `gcd_done` in 1: `gcd.done`.
- `gcd_result` in DW: `gcd.result`.

## Operation
- States:
  - IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is set, the round-robin grant picks the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[g]` = 1 for the granted index only. The request is accepted on that cycle.
  - On accept, operands and ID are registered, `rr_ptr` <= g+1 (mod NUM_REQ), and the FSM goes to ISSUE.
- ISSUE:
  - `gcd_start` = 1 for exactly this one cycle. `gcd_a`/`gcd_b` present the registered operands.
  - Next state is WAIT.
- WAIT:
  - `gcd_a`/`gcd_b` remain stable.
  - On the first cycle with `gcd_done`=1, capture `gcd_result` and go to RESP.
  - `gcd_done` is ignored in every other state; a stale done from a prior operation cannot complete a new one.
- RESP:
  - `resp_valid` = 1 while `resp_id`, `resp_result` and `resp_error` are held stable.
  - On `resp_valid && resp_ready`, go to IDLE.
  - `resp_ready` low stalls indefinitely; no new request is accepted meanwhile.
- No requests are accepted outside IDLE; `req_ready` = 0 in ISSUE, WAIT and RESP.
- Requesters must hold `req_valid` and operands until `req_ready`.
- Operands are forwarded unmodified. Zero-operand behaviour is defined by `gcd`, not by this block.
- Fairness: a requester that is continuously valid is served within NUM_REQ grants.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - All outputs are 0. `rr_ptr` = 0, state = IDLE, operand/result registers = 0.
  - Reset mid-operation drops the in-flight request silently. The requester must re-issue it.
- Latency:
  - Accept at cycle T, `gcd_start` at T+1, WAIT from T+2.
  - If `gcd_done` is seen at cycle D, `resp_valid` is set at D+1.
  - Minimum accept-to-response latency is 3 cycles plus the `gcd` compute time.
- Throughput: at most one operation in flight. The next accept is possible in the cycle after the response handshake.
- Simultaneous requests are resolved by `rr_ptr` alone; there is no priority input.

## Configuration
- `GCD_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT, cleared on entry.
  - If it reaches TIMEOUT_CYCLES with no `gcd_done`, go to RESP with `resp_error`=1 and `resp_result`=0.
- `GCD_ARB_TIMEOUT_EN` undefined:
  - No counter is built, `resp_error` is constant 0, and WAIT waits forever.

## Structure
- Package `gcd_arb_pkg` holds:
  - the state enum `gcd_arb_state_t` (IDLE, ISSUE, WAIT, RESP),
  - the `DW` default constant,
  - the `id_width(n)` function.
- Sub-module `rr_arbiter` contains the combinational grant from `req_valid` and `rr_ptr`, producing a one-hot grant plus an encoded index.
- Top `gcd_arbiter` contains the FSM, registers and the optional watchdog.

## Test plan
- Single request: req 2 with a=48, b=18 → `gcd_start` one cycle after accept; response `resp_id`=2, `resp_result`=6, `resp_error`=0.
- All 4 valid from reset → grants in order 0,1,2,3. Operands (12,8), (35,21), (17,5), (100,75) → results 4, 7, 1, 25, in that order.
- Back-pressure: `resp_ready`=0 for 10 cycles in RESP → `resp_valid`, `resp_id` and `resp_result` held stable; `req_ready` stays 0; completes on the first `resp_ready`=1.
- Stale done: `gcd_done` forced high during IDLE and ISSUE → no response until `gcd_done` is seen in WAIT.
- Reset mid-WAIT: `reset_n` low for 1 cycle → all outputs 0 and state IDLE immediately; requester 0 is granted first afterward.
- With `GCD_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, `gcd_done` held 0 → `resp_valid` set 17 cycles after WAIT entry, with `resp_error`=1 and `resp_result`=0.
